// File: rtl/bmc_soft_pipe.sv
// Two-stage pipelined soft-decision branch metric unit for the Viterbi ACS array.
// Optional macro BMC_ERASURE_EN adds an in_erase port that zeroes punctured bits.
module bmc_soft_pipe #(
  parameter int  N_OUT       = 2,
  parameter int  SOFT_W      = 3,
  parameter int  FRAME_CNT_W = 10,
  localparam int BM_W        = $clog2(N_OUT*(2**SOFT_W-1)+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_OUT*SOFT_W-1:0]    in_sym,
`ifdef BMC_ERASURE_EN
  input  logic [N_OUT-1:0]           in_erase,
`endif
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(2**N_OUT)*BM_W-1:0] out_bm,
  output logic [N_OUT-1:0]           out_min_idx,
  output logic                       out_last,
  output logic [FRAME_CNT_W-1:0]     out_sym_cnt
);

  localparam int NCW = 2**N_OUT;

  logic adv1, adv2, outFire;

  logic                          s1_valid_q, s1_last_q;
  logic [N_OUT-1:0][SOFT_W-1:0]  s1_dist0_q, s1_dist1_q;
  logic [N_OUT-1:0][SOFT_W-1:0]  s1_dist0_d, s1_dist1_d;

  logic                          s2_valid_q, s2_last_q;
  logic [NCW-1:0][BM_W-1:0]      s2_bm_q, s2_bm_d;
  logic [N_OUT-1:0]              s2_min_q, s2_min_d;
  logic [BM_W-1:0]               minVal;

  logic [FRAME_CNT_W-1:0]        cnt_q;

  always_comb begin
    adv2     = !s2_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    in_ready = adv1;
    outFire  = s2_valid_q && out_ready;
  end

  // Distance to an expected 1 is MAX-r, which for an all-ones MAX is just ~r.
  always_comb begin
    s1_dist0_d = '0;
    s1_dist1_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      s1_dist0_d[j] = in_sym[j*SOFT_W +: SOFT_W];
      s1_dist1_d[j] = ~in_sym[j*SOFT_W +: SOFT_W];
`ifdef BMC_ERASURE_EN
      if (in_erase[j]) begin
        s1_dist0_d[j] = '0;
        s1_dist1_d[j] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_dist0_q <= '0;
      s1_dist1_q <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_last_q  <= in_last;
        s1_dist0_q <= s1_dist0_d;
        s1_dist1_q <= s1_dist1_d;
      end
    end
  end

  // Strict less-than while scanning upward keeps the lowest index among equal minima.
  always_comb begin
    s2_bm_d  = '0;
    s2_min_d = '0;
    minVal   = '0;
    for (int c = 0; c < NCW; c++) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (((c >> j) & 1) == 1)
          s2_bm_d[c] = s2_bm_d[c] + BM_W'(s1_dist1_q[j]);
        else
          s2_bm_d[c] = s2_bm_d[c] + BM_W'(s1_dist0_q[j]);
      end
    end
    minVal = s2_bm_d[0];
    for (int c = 1; c < NCW; c++) begin
      if (s2_bm_d[c] < minVal) begin
        minVal   = s2_bm_d[c];
        s2_min_d = N_OUT'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_bm_q    <= '0;
      s2_min_q   <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_last_q <= s1_last_q;
        s2_bm_q   <= s2_bm_d;
        s2_min_q  <= s2_min_d;
      end
    end
  end

  // The counter always holds the position of the symbol currently in S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (outFire) begin
      if (s2_last_q) cnt_q <= '0;
      else           cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_bm      = s2_bm_q;
  assign out_min_idx = s2_min_q;
  assign out_last    = s2_last_q;
  assign out_sym_cnt = cnt_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Self-checking bench for bmc_soft_pipe: vector table plus scoreboard on the default
// configuration, and a second small instance (SOFT_W=1, FRAME_CNT_W=2) for hard decisions.
module tb_bmc_soft_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [5:0]  in_sym;
  logic [1:0]  in_erase;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_bm;
  logic [1:0]  out_min_idx;
  logic [9:0]  out_sym_cnt;

  logic        in_valid2, in_ready2, in_last2;
  logic [1:0]  in_sym2;
  logic [1:0]  in_erase2;
  logic        out_valid2, out_last2;
  logic        out_ready2;
  logic [7:0]  out_bm2;
  logic [1:0]  out_min_idx2;
  logic [1:0]  out_sym_cnt2;

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(3), .FRAME_CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym),
`ifdef BMC_ERASURE_EN
    .in_erase(in_erase),
`endif
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_bm(out_bm), .out_min_idx(out_min_idx), .out_last(out_last),
    .out_sym_cnt(out_sym_cnt)
  );

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(1), .FRAME_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sym(in_sym2),
`ifdef BMC_ERASURE_EN
    .in_erase(in_erase2),
`endif
    .in_last(in_last2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_bm(out_bm2), .out_min_idx(out_min_idx2), .out_last(out_last2),
    .out_sym_cnt(out_sym_cnt2)
  );

  typedef struct {
    logic [15:0] bm;
    logic [1:0]  minIdx;
    logic        last;
    logic [9:0]  cnt;
  } exp_t;

  typedef struct {
    logic [5:0]  sym;
    logic        last;
    logic [1:0]  erase;
    logic [15:0] bm;
    logic [1:0]  minIdx;
  } vec_t;

  exp_t        scoreQ[$];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  int          readyMode = 0;
  int          stallStart = 0;
  int          popCount = 0;
  logic [9:0]  expCnt = '0;
  bit          stallWatch = 0;
  bit          sawStall = 0;
  bit          prevHeld = 0;
  logic [28:0] heldVal;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference metric: absolute distance from each soft value to its ideal level.
  function automatic void modelOf(input logic [5:0] sym, input logic [1:0] erase,
                                  output logic [15:0] bm, output logic [1:0] minIdx);
    int s, r, tgt, best;
    bm = '0;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int j = 0; j < 2; j++) begin
        if (!erase[j]) begin
          r   = int'(sym[j*3 +: 3]);
          tgt = (((c >> j) & 1) == 1) ? 7 : 0;
          s  += (r > tgt) ? (r - tgt) : (tgt - r);
        end
      end
      bm[c*4 +: 4] = 4'(s);
    end
    best = 0;
    for (int c = 1; c < 4; c++)
      if (bm[c*4 +: 4] < bm[best*4 +: 4]) best = c;
    minIdx = 2'(best);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic applyStimulus(input logic [5:0] sym, input logic last, input logic [1:0] erase,
                               input logic [15:0] bm, input logic [1:0] minIdx);
    int   n;
    exp_t e;
    in_valid = 1'b1;
    in_sym   = sym;
    in_last  = last;
    in_erase = erase;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.bm     = bm;
      e.minIdx = minIdx;
      e.last   = last;
      e.cnt    = expCnt;
      expCnt   = last ? 10'd0 : expCnt + 10'd1;
      scoreQ.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sym   = 6'($urandom);
    in_erase = '0;
  endtask

  task automatic sendModel(input logic [5:0] sym, input logic last);
    logic [15:0] bm;
    logic [1:0]  mi;
    modelOf(sym, 2'b00, bm, mi);
    applyStimulus(sym, last, 2'b00, bm, mi);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((scoreQ.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 64'(scoreQ.size()), 64'd0);
  endtask

  task automatic sendSym2(input logic [1:0] sym, input logic last, input logic [7:0] bm,
                          input logic [1:0] minIdx, input logic [1:0] cnt, input logic lastExp);
    int n;
    checkOutput("dut2_in_ready", 64'(in_ready2), 64'd1);
    in_valid2 = 1'b1;
    in_sym2   = sym;
    in_last2  = last;
    @(negedge clk);
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    in_sym2   = 2'($urandom);
    n = 0;
    while (!out_valid2 && n < 5) begin
      @(negedge clk);
      n++;
    end
    checkOutput("dut2_out_valid", 64'(out_valid2), 64'd1);
    if (out_valid2) begin
      checkOutput("dut2_bm", 64'(out_bm2), 64'(bm));
      checkOutput("dut2_min_idx", 64'(out_min_idx2), 64'(minIdx));
      checkOutput("dut2_sym_cnt", 64'(out_sym_cnt2), 64'(cnt));
      checkOutput("dut2_last", 64'(out_last2), 64'(lastExp));
    end
  endtask

  // out_ready changes just after each posedge so it is settled at every negedge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cycleCnt++;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cycleCnt >= stallStart && cycleCnt < stallStart + 4);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevHeld = 0;
      end else begin
        if (stallWatch && !in_ready) sawStall = 1;
        if (prevHeld)
          checkOutput("held_outputs", 64'({out_valid, out_bm, out_min_idx, out_last, out_sym_cnt}),
                      64'({1'b1, heldVal}));
        if (out_valid && out_ready) begin
          if (scoreQ.size() == 0) begin
            checkOutput("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = scoreQ.pop_front();
            popCount++;
            checkOutput("out_bm", 64'(out_bm), 64'(e.bm));
            checkOutput("out_min_idx", 64'(out_min_idx), 64'(e.minIdx));
            checkOutput("out_last", 64'(out_last), 64'(e.last));
            checkOutput("out_sym_cnt", 64'(out_sym_cnt), 64'(e.cnt));
          end
        end
        prevHeld = out_valid && !out_ready;
        heldVal  = {out_bm, out_min_idx, out_last, out_sym_cnt};
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startPop;
    rst_n     = 1'b0;
    in_valid  = 1'b0; in_sym  = '0; in_last  = 1'b0; in_erase  = '0;
    in_valid2 = 1'b0; in_sym2 = '0; in_last2 = 1'b0; in_erase2 = '0;
    out_ready2 = 1'b1;

    vecs.push_back('{6'h07, 1'b0, 2'b00, {4'd7, 4'd14, 4'd0, 4'd7}, 2'd1});
    vecs.push_back('{6'h00, 1'b0, 2'b00, {4'd14, 4'd7, 4'd7, 4'd0}, 2'd0});
    vecs.push_back('{6'h3F, 1'b0, 2'b00, {4'd0, 4'd7, 4'd7, 4'd14}, 2'd3});
    vecs.push_back('{6'h23, 1'b0, 2'b00, {4'd7, 4'd6, 4'd8, 4'd7}, 2'd2});
    vecs.push_back('{6'h1C, 1'b0, 2'b00, {4'd7, 4'd8, 4'd6, 4'd7}, 2'd1});
`ifdef BMC_ERASURE_EN
    vecs.push_back('{6'h07, 1'b0, 2'b10, {4'd0, 4'd7, 4'd0, 4'd7}, 2'd1});
    vecs.push_back('{6'h07, 1'b0, 2'b11, 16'h0000, 2'd0});
    vecs.push_back('{6'h38, 1'b0, 2'b01, {4'd0, 4'd0, 4'd7, 4'd7}, 2'd2});
`endif
    vecs.push_back('{6'h29, 1'b1, 2'b00, {4'd8, 4'd3, 4'd11, 4'd6}, 2'd2});

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_bm", 64'(out_bm), 64'd0);
    checkOutput("reset_min_last_cnt", 64'({out_min_idx, out_last, out_sym_cnt}), 64'd0);
    rst_n = 1'b1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] latency check");
    applyStimulus(vecs[0].sym, 1'b0, 2'b00, vecs[0].bm, vecs[0].minIdx);
    checkOutput("latency_after_s1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("latency_after_s2", 64'(out_valid), 64'd1);
    waitDrain();

    $display("[TB] vector table");
    foreach (vecs[i])
      applyStimulus(vecs[i].sym, vecs[i].last, vecs[i].erase, vecs[i].bm, vecs[i].minIdx);
    waitDrain();

    $display("[TB] frame counter");
    for (int i = 0; i < 5; i++) sendModel(6'($urandom), (i == 4));
    for (int i = 0; i < 3; i++) sendModel(6'($urandom), 1'b0);
    waitDrain();

    $display("[TB] stall stream");
    startPop   = popCount;
    sawStall   = 0;
    stallWatch = 1;
    readyMode  = 1;
    stallStart = cycleCnt + 3;
    for (int i = 0; i < 8; i++) sendModel(6'($urandom), 1'b0);
    waitDrain();
    stallWatch = 0;
    readyMode  = 0;
    checkOutput("stall_in_ready_dropped", 64'(sawStall), 64'd1);
    checkOutput("stall_output_count", 64'(popCount - startPop), 64'd8);

    $display("[TB] mid-stream reset");
    readyMode = 2;
    @(negedge clk);
    sendModel(6'h11, 1'b0);
    sendModel(6'h22, 1'b0);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("async_reset_cnt", 64'(out_sym_cnt), 64'd0);
    scoreQ.delete();
    expCnt = '0;
    readyMode = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hold_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    sendModel(6'h05, 1'b0);
    waitDrain();

    $display("[TB] hard-decision instance");
    sendSym2(2'b11, 1'b0, {2'd0, 2'd1, 2'd1, 2'd2}, 2'd3, 2'd0, 1'b0);
    sendSym2(2'b01, 1'b1, {2'd1, 2'd2, 2'd0, 2'd1}, 2'd1, 2'd1, 1'b1);
    for (int i = 0; i < 6; i++)
      sendSym2(2'b00, (i == 5), {2'd2, 2'd1, 2'd1, 2'd0}, 2'd0, 2'(i % 4), (i == 5));
    sendSym2(2'b00, 1'b0, {2'd2, 2'd1, 2'd1, 2'd0}, 2'd0, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
